v810_intc: RTL
==============

Name: v810_intc

Overview:
Memory-mapped interrupt controller on the V810 bus. It aggregates 16 peripheral request lines into the CPU's INT / INTVn level inputs and generates a pulsed NMIn. It acts as a bus responder, answering CPU cycles for its register window with programmable wait states. It sits between the peripherals and the v810 core, and shares the core's D/A/READYn bus with the RAMs.

Parameters:
WAIT, 1, wait cycles inserted before READYn asserts (0..7)
NMI_PULSE, 2, NMIn low time in CE cycles (1..15)

Ports:
CLK  in  1  system clock
RES  in  1  synchronous reset, active-high
CE  in  1  clock enable; all state advances only when CE=1
CS  in  1  address-decode select for this block's window
A  in  5  CPU A[6:2], word offset
D_I  in  32  write data (CPU D_O)
D_O  out  32  read data
BEn  in  4  byte enables, active-low
MRQn  in  1  memory request, active-low
RW  in  1  1=read, 0=write
BCYSTn  in  1  bus cycle start, active-low
READYn  out  1  transfer complete, active-low
SZRQn  out  1  bus sizing request; constant 1 (32-bit port)
IRQ  in  16  peripheral requests, synchronous to CLK
NMI_SRC  in  1  NMI request, rising-edge sensitive
INT  out  1  maskable interrupt request to CPU
INTVn  out  4  inverted interrupt level to CPU
NMIn  out  1  NMI to CPU, active-low

Behaviour:
- Reset values: READYn=1, INT=0, INTVn=4'hF, NMIn=1, D_O=0; PEND=MASK=MODE=0; bus FSM in IDLE; NMI counter=0.
- CE=0: all registers hold their state; outputs hold their values.
- Registers, by word offset A[4:2]. Offsets 5-7 read 0, and writes to them are ignored:
  - 0 PEND: read returns pending bits. Write-1-clears edge-mode bits only.
  - 1 MASK: read/write; 1 = enabled.
  - 2 MODE: read/write; 1 = edge, 0 = level.
  - 3 STAT: read-only. [3:0] current INTV level, [4] INT, [5] NMI pulse active.
  - 4 SWI: write-only. Writing 1s sets PEND bits for edge-mode sources; reads return 0.
- Byte writes: only bytes with BEn[k]=0 are updated.
- Pending logic:
  - Level-mode bit: PEND[i] <= IRQ[i] every cycle.
  - Edge-mode bit: set on IRQ[i] 0->1, using a registered previous value that updates every CE cycle.
  - Edge set and W1C on the same cycle: set wins.
  - MODE change edge->level: the bit follows IRQ from the next cycle.
- Priority: eff = PEND & MASK. The level is the highest set index (15 highest).
  - INT and INTVn are registered. They reflect eff one CE cycle after PEND changes.
  - eff=0 gives INT=0 and INTVn=4'hF.
  - The CPU has no acknowledge cycle. Software clears PEND or MASK; the request is removed one cycle after that write commits.
- NMI: a NMI_SRC rising edge loads the counter with NMI_PULSE, and NMIn=0 while the counter is nonzero.
  - A new edge during an active pulse reloads the counter (no second falling edge).
- Bus FSM states: IDLE, WAIT, READY.
  - IDLE: start when CE & ~BCYSTn & ~MRQn & CS. Latch A, RW, BEn. Go to WAIT with cnt=WAIT, or directly to READY if WAIT=0.
  - WAIT: cnt decrements; at cnt==1, go to READY.
  - READY: READYn=0 for exactly one CE cycle. D_O is valid for reads; for writes, D_I is sampled and committed at the end of this cycle. Then:
    - A qualifying start in the READY cycle goes to WAIT/READY (back-to-back cycles).
    - Otherwise go to IDLE.
  - D_O returns to 0 outside READY.
  - BCYSTn while in WAIT is ignored.
  - Total latency: READYn low in cycle 1+WAIT after the BCYSTn cycle.
  - A cycle with CS=0 produces no response; READYn stays 1.
- Reset mid-cycle: the FSM goes to IDLE, READYn=1, and no write is committed.
- Read-side effects: none.

Decomposition:
- Package v810_intc_pkg:
  - register offset localparams (REG_PEND=0 .. REG_SWI=4)
  - typedef enum logic [1:0] bus_state_t {IDLE, WAIT, READY}
  - typedef logic [15:0] irq_vec_t
- Sub-module v810_intc_prienc: combinational 16->4 priority encoder plus any-set flag, reused by the priority logic. All sequential logic stays in v810_intc.

Test Plan:
1. Reset, then read offset 1 with WAIT=1 -> READYn low exactly 2 cycles after BCYSTn, D_O=0. INT=0, INTVn=4'hF, NMIn=1.
2. Write MASK=16'h0180 and MODE=0, then drive IRQ[8]=1 and IRQ[7]=1 -> INT=1 and INTVn=~4'd8 one cycle later. Drop IRQ[8] -> INTVn=~4'd7. Drop IRQ[7] -> INT=0.
3. Set MODE[3]=1 and MASK[3]=1, pulse IRQ[3] for 1 cycle -> PEND=16'h0008 holds. Write PEND=16'h0008 on the same cycle as a new IRQ[3] edge -> bit stays set. Clear again -> INT=0.
4. Pulse NMI_SRC for 1 cycle with NMI_PULSE=2 -> NMIn low exactly 2 cycles. Second edge mid-pulse -> low time extends, with a single falling edge.
5. Byte write BEn=4'b1110 with data 32'hFFFF_FFFF to MASK -> MASK=16'h00FF. Write 32'h0000_0010 to SWI with MODE[4]=1 -> PEND[4]=1, and INT follows MASK.
6. Assert RES during WAIT of a write to MASK -> READYn stays 1 and MASK=0. Back-to-back reads with BCYSTn in the READY cycle -> two READYn pulses with no IDLE gap.

Source files
------------

// File: rtl/v810_intc_pkg.sv
// Shared types and register map for the V810 interrupt controller.
package v810_intc_pkg;

    // Word offsets within the register window (decoded from A[4:2] of the CPU address)
    localparam logic [2:0] REG_PEND = 3'd0;
    localparam logic [2:0] REG_MASK = 3'd1;
    localparam logic [2:0] REG_MODE = 3'd2;
    localparam logic [2:0] REG_STAT = 3'd3;
    localparam logic [2:0] REG_SWI  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } bus_state_t;

    typedef logic [15:0] irq_vec_t;

endpackage

// File: rtl/v810_intc_prienc.sv
// 16-to-4 priority encoder: index of the highest set bit plus an any-set flag.
module v810_intc_prienc
    import v810_intc_pkg::*;
(
    input  logic [15:0] vec,
    output logic [3:0]  lvl,
    output logic        any
);

    // Scan upward so the highest set index wins
    always_comb begin
        lvl = 4'd0;
        any = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                lvl = 4'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/v810_intc.sv
// V810 interrupt controller: bus responder with wait states, pending/mask/mode
// registers, registered INT/INTVn priority output and a stretched NMIn pulse.
module v810_intc #(
    parameter int WAIT      = 1,
    parameter int NMI_PULSE = 2
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic        CS,
    input  logic [4:0]  A,
    input  logic [31:0] D_I,
    output logic [31:0] D_O,
    input  logic [3:0]  BEn,
    input  logic        MRQn,
    input  logic        RW,
    input  logic        BCYSTn,
    output logic        READYn,
    output logic        SZRQn,
    input  logic [15:0] IRQ,
    input  logic        NMI_SRC,
    output logic        INT,
    output logic [3:0]  INTVn,
    output logic        NMIn
);
    import v810_intc_pkg::*;

    // The WAIT parameter shadows the state name, so the state is referenced by package scope
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT);
    localparam logic [3:0] NMI_LOAD  = 4'(NMI_PULSE);

    bus_state_t  state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        latch;
    logic        start;
    logic [2:0]  a_q;
    logic        rw_q;
    logic [1:0]  be_q;

    irq_vec_t    pend, mask, mode, irq_prev;
    irq_vec_t    wmask, wdata, pend_clr, pend_swi, eff;
    logic        wr_commit;
    logic [3:0]  lvl;
    logic        any;
    logic        int_q;
    logic [3:0]  intvn_q;
    logic [3:0]  nmi_cnt;
    logic        nmi_prev;
    logic [15:0] rdata;
    logic        unused_bits;

    // Registers are 16 bits wide, so upper data lanes and A[6:5] are don't-care
    assign unused_bits = ^{D_I[31:16], A[4:3], BEn[3:2]};

    assign start = ~BCYSTn & ~MRQn & CS;

    // Bus responder next state: a start is accepted from IDLE or from READY (back-to-back)
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        latch    = 1'b0;
        case (state)
            IDLE, READY: begin
                state_nx = IDLE;
                if (start) begin
                    latch = 1'b1;
                    if (WAIT == 0) begin
                        state_nx = READY;
                    end else begin
                        state_nx = v810_intc_pkg::WAIT;
                        cnt_nx   = WAIT_LOAD;
                    end
                end
            end
            v810_intc_pkg::WAIT: begin
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd1) state_nx = READY;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bus state register and the address/direction/byte-enable latch
    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= IDLE;
            cnt   <= 3'd0;
            a_q   <= 3'd0;
            rw_q  <= 1'b1;
            be_q  <= 2'b11;
        end else if (CE) begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (latch) begin
                a_q  <= A[2:0];
                rw_q <= RW;
                be_q <= BEn[1:0];
            end
        end
    end

    // Read mux; offsets 5-7 and SWI read as zero
    always_comb begin
        rdata = 16'h0000;
        case (a_q)
            REG_PEND: rdata = pend;
            REG_MASK: rdata = mask;
            REG_MODE: rdata = mode;
            REG_STAT: rdata = {10'h000, (nmi_cnt != 4'd0), int_q, ~intvn_q};
            default:  rdata = 16'h0000;
        endcase
    end

    assign READYn = (state != READY);
    assign SZRQn  = 1'b1;
    assign D_O    = (state == READY && rw_q) ? {16'h0000, rdata} : 32'h0000_0000;

    // A write takes effect at the end of the READY cycle, restricted to enabled bytes
    assign wr_commit = (state == READY) & ~rw_q;
    assign wmask     = {{8{~be_q[1]}}, {8{~be_q[0]}}};
    assign wdata     = D_I[15:0] & wmask;
    assign pend_clr  = (wr_commit && a_q == REG_PEND) ? wdata : '0;
    assign pend_swi  = (wr_commit && a_q == REG_SWI)  ? wdata : '0;
    assign eff       = pend & mask;

    // Pending/mask/mode registers; in edge mode a new edge or SWI beats a same-cycle clear
    always_ff @(posedge CLK) begin
        if (RES) begin
            pend     <= '0;
            mask     <= '0;
            mode     <= '0;
            irq_prev <= '0;
        end else if (CE) begin
            irq_prev <= IRQ;
            pend     <= (~mode & IRQ)
                      | (mode & ((pend & ~pend_clr) | (IRQ & ~irq_prev) | pend_swi));
            if (wr_commit && a_q == REG_MASK) mask <= (mask & ~wmask) | wdata;
            if (wr_commit && a_q == REG_MODE) mode <= (mode & ~wmask) | wdata;
        end
    end

    v810_intc_prienc u_prienc (
        .vec (eff),
        .lvl (lvl),
        .any (any)
    );

    // Registered CPU interrupt level; INTVn is all-ones when nothing is enabled and pending
    always_ff @(posedge CLK) begin
        if (RES) begin
            int_q   <= 1'b0;
            intvn_q <= 4'hF;
        end else if (CE) begin
            int_q   <= any;
            intvn_q <= ~lvl;
        end
    end

    // NMI pulse stretcher; a fresh edge reloads the counter so NMIn stays low continuously
    always_ff @(posedge CLK) begin
        if (RES) begin
            nmi_cnt  <= 4'd0;
            nmi_prev <= 1'b0;
        end else if (CE) begin
            nmi_prev <= NMI_SRC;
            if (NMI_SRC && !nmi_prev) nmi_cnt <= NMI_LOAD;
            else if (nmi_cnt != 4'd0) nmi_cnt <= nmi_cnt - 4'd1;
        end
    end

    assign INT   = int_q;
    assign INTVn = intvn_q;
    assign NMIn  = (nmi_cnt == 4'd0);

endmodule
